// File: rtl/soric_bank_xbar.sv
// N-master x M-bank SRAM crossbar: per-bank round-robin arbitration, fixed-latency
// in-order response pipeline per master, and error responses for unpopulated addresses.
module soric_bank_xbar #(
    parameter int NMASTER     = 2,
    parameter int NBANK       = 4,
    parameter int ADDR_W      = 14,
    parameter int BANK_ADDR_W = 11,
    parameter int RD_LAT      = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NMASTER-1:0]           m_req_i,
    input  logic [NMASTER*ADDR_W-1:0]    m_addr_i,
    input  logic [NMASTER-1:0]           m_we_i,
    input  logic [NMASTER*4-1:0]         m_be_i,
    input  logic [NMASTER*32-1:0]        m_wdata_i,
    output logic [NMASTER-1:0]           m_gnt_o,
    output logic [NMASTER-1:0]           m_rvalid_o,
    output logic [NMASTER*32-1:0]        m_rdata_o,
    output logic [NMASTER-1:0]           m_err_o,
    output logic [NBANK-1:0]             s_req_o,
    output logic [NBANK*BANK_ADDR_W-1:0] s_addr_o,
    output logic [NBANK-1:0]             s_we_o,
    output logic [NBANK*4-1:0]           s_be_o,
    output logic [NBANK*32-1:0]          s_wdata_o,
    input  logic [NBANK*32-1:0]          s_rdata_i
);

    localparam int BIDX_W = $clog2(NBANK);
    localparam int PTR_W  = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int HI_W   = ADDR_W - BANK_ADDR_W - BIDX_W;
    localparam int TAP    = RD_LAT - 1;

    logic [BIDX_W-1:0]      dec_bank [NMASTER];
    logic [BANK_ADDR_W-1:0] dec_off  [NMASTER];
    logic [NMASTER-1:0]     dec_oor;

    logic [PTR_W-1:0]       ptr [NBANK];
    logic [PTR_W-1:0]       win [NBANK];
    logic [NBANK-1:0]       bank_hit;
    logic [NMASTER-1:0]     arb_gnt;

    logic [RD_LAT-1:0]      pv   [NMASTER];
    logic [RD_LAT-1:0]      perr [NMASTER];
    logic [RD_LAT-1:0]      pwe  [NMASTER];
    logic [BIDX_W-1:0]      pbank [NMASTER][RD_LAT];

    for (genvar k = 0; k < NMASTER; k++) begin : g_dec
        assign dec_bank[k] = m_addr_i[k*ADDR_W + BANK_ADDR_W +: BIDX_W];
        assign dec_off[k]  = m_addr_i[k*ADDR_W +: BANK_ADDR_W];
        if (HI_W > 0) begin : g_hi
            assign dec_oor[k] = |m_addr_i[k*ADDR_W + BANK_ADDR_W + BIDX_W +: HI_W];
        end else begin : g_nohi
            assign dec_oor[k] = 1'b0;
        end
    end

    // Round-robin: first scan masters at or above ptr, then wrap to those below it.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        bank_hit = '0;
        arb_gnt  = '0;
        for (int b = 0; b < NBANK; b++) begin
            win[b] = '0;
            for (int k = 0; k < NMASTER; k++) begin
                if (!bank_hit[b] && k >= int'(ptr[b]) && m_req_i[k] && !dec_oor[k]
                    && dec_bank[k] == BIDX_W'(b)) begin
                    bank_hit[b] = 1'b1;
                    win[b]      = PTR_W'(k);
                end
            end
            for (int k = 0; k < NMASTER; k++) begin
                if (!bank_hit[b] && m_req_i[k] && !dec_oor[k] && dec_bank[k] == BIDX_W'(b)) begin
                    bank_hit[b] = 1'b1;
                    win[b]      = PTR_W'(k);
                end
            end
            if (bank_hit[b]) arb_gnt[win[b]] = 1'b1;
        end
    end

    // Out-of-range requests bypass arbitration and never touch a bank.
    assign m_gnt_o = arb_gnt | (m_req_i & dec_oor);

    always_comb begin
        s_req_o   = bank_hit;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (bank_hit[b]) begin
                s_addr_o[b*BANK_ADDR_W +: BANK_ADDR_W] = dec_off[win[b]];
                s_we_o[b]                              = m_we_i[win[b]];
                s_be_o[b*4 +: 4]                       = m_be_i[32'(win[b])*4 +: 4];
                s_wdata_o[b*32 +: 32]                  = m_wdata_i[32'(win[b])*32 +: 32];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NBANK; b++) ptr[b] <= '0;
            for (int k = 0; k < NMASTER; k++) pv[k] <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (bank_hit[b]) begin
                    ptr[b] <= (32'(win[b]) == NMASTER - 1) ? '0 : win[b] + 1'b1;
                end
            end
            for (int k = 0; k < NMASTER; k++) begin
                for (int s = RD_LAT - 1; s > 0; s--) pv[k][s] <= pv[k][s-1];
                pv[k][0] <= m_gnt_o[k];
            end
        end
    end

    // NOTE: response side-band fields are only meaningful under pv, so they carry no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NMASTER; k++) begin
            for (int s = RD_LAT - 1; s > 0; s--) begin
                perr[k][s]  <= perr[k][s-1];
                pwe[k][s]   <= pwe[k][s-1];
                pbank[k][s] <= pbank[k][s-1];
            end
            perr[k][0]  <= dec_oor[k];
            pwe[k][0]   <= m_we_i[k];
            pbank[k][0] <= dec_bank[k];
        end
    end

    // Read data is steered straight from the recorded bank in the tap cycle.
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        for (int k = 0; k < NMASTER; k++) begin
            m_rvalid_o[k] = pv[k][TAP];
            m_err_o[k]    = pv[k][TAP] & perr[k][TAP];
            if (pv[k][TAP] && !perr[k][TAP] && !pwe[k][TAP]) begin
                m_rdata_o[k*32 +: 32] = s_rdata_i[32'(pbank[k][TAP])*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_soric_bank_xbar.sv
// Bench for soric_bank_xbar: RD_LAT=1 and RD_LAT=2 instances on shared stimulus;
// vector table, directed corner sequences, and a randomized run against a behavioural model.
module tb_soric_bank_xbar;

    localparam int NM   = 2;
    localparam int NB   = 4;
    localparam int AW   = 14;
    localparam int BAW  = 11;
    localparam int NCYC = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]     m_req, m_we;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*4-1:0]   m_be;
    logic [NM*32-1:0]  m_wdata;
    logic [NB*32-1:0]  s_rdata;

    logic [NM-1:0]     gnt1, rv1, err1, gnt2, rv2, err2;
    logic [NM*32-1:0]  rd1, rd2;
    logic [NB-1:0]     sreq1, swe1, sreq2, swe2;
    logic [NB*BAW-1:0] saddr1, saddr2;
    logic [NB*4-1:0]   sbe1, sbe2;
    logic [NB*32-1:0]  swd1, swd2;

    soric_bank_xbar #(.NMASTER(NM), .NBANK(NB), .ADDR_W(AW), .BANK_ADDR_W(BAW), .RD_LAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(gnt1), .m_rvalid_o(rv1), .m_rdata_o(rd1), .m_err_o(err1),
        .s_req_o(sreq1), .s_addr_o(saddr1), .s_we_o(swe1), .s_be_o(sbe1), .s_wdata_o(swd1),
        .s_rdata_i(s_rdata)
    );

    soric_bank_xbar #(.NMASTER(NM), .NBANK(NB), .ADDR_W(AW), .BANK_ADDR_W(BAW), .RD_LAT(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(gnt2), .m_rvalid_o(rv2), .m_rdata_o(rd2), .m_err_o(err2),
        .s_req_o(sreq2), .s_addr_o(saddr2), .s_we_o(swe2), .s_be_o(sbe2), .s_wdata_o(swd2),
        .s_rdata_i(s_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic req, input logic [AW-1:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        m_req[k]             = req;
        m_addr[k*AW +: AW]   = a;
        m_we[k]              = we;
        m_be[k*4 +: 4]       = be;
        m_wdata[k*32 +: 32]  = wd;
    endtask

    task automatic idle();
        m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        s_rdata = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0, a1;
        logic [1:0]    we;
        logic [1:0]    gnt;
        logic [3:0]    sreq;
        logic [1:0]    rv, err;
        logic [31:0]   rd0, rd1;
    } vec_t;
    vec_t tbl [9];

    // Behavioural model state for the random run.
    int            mptr [NB];
    bit            hv [NCYC][NM];
    int            hb [NCYC][NM];
    bit            he [NCYC][NM];
    bit            hw [NCYC][NM];

    initial begin
        logic [NB*32-1:0] pat;
        pat = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h0BAD0000};

        //            req    a0        a1        we     gnt    sreq     rv     err    rd0           rd1
        tbl[0] = '{2'b01, 14'h0804, 14'h0000, 2'b00, 2'b01, 4'b0010, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{2'b10, 14'h0000, 14'h2000, 2'b00, 2'b10, 4'b0000, 2'b10, 2'b10, 32'h0,        32'h0};
        tbl[2] = '{2'b11, 14'h0000, 14'h1804, 2'b01, 2'b11, 4'b1001, 2'b11, 2'b00, 32'h0,        32'h33333333};
        tbl[3] = '{2'b11, 14'h1000, 14'h1010, 2'b00, 2'b01, 4'b0100, 2'b01, 2'b00, 32'h22222222, 32'h0};
        tbl[4] = '{2'b11, 14'h1000, 14'h1010, 2'b00, 2'b10, 4'b0100, 2'b10, 2'b00, 32'h0,        32'h22222222};
        tbl[5] = '{2'b11, 14'h3FFC, 14'h3000, 2'b00, 2'b11, 4'b0000, 2'b11, 2'b11, 32'h0,        32'h0};
        tbl[6] = '{2'b11, 14'h0800, 14'h0FFC, 2'b00, 2'b10, 4'b0010, 2'b10, 2'b00, 32'h0,        32'hDEADBEEF};
        tbl[7] = '{2'b00, 14'h0800, 14'h0FFC, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 32'h0,        32'h0};
        tbl[8] = '{2'b11, 14'h0800, 14'h2800, 2'b00, 2'b11, 4'b0010, 2'b11, 2'b10, 32'hDEADBEEF, 32'h0};

        idle();
        s_rdata = '0;
        #12;
        check("reset_rvalid", 32'(rv1), 32'h0);
        check("reset_err", 32'(err1), 32'h0);
        check("reset_rdata", rd1[31:0] | rd1[63:32], 32'h0);
        check("reset_gnt_sreq", {24'h0, sreq1, 2'b00, gnt1}, 32'h0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(0, tbl[i].req[0], tbl[i].a0, tbl[i].we[0], 4'hF, 32'h12345678);
            drive(1, tbl[i].req[1], tbl[i].a1, tbl[i].we[1], 4'hF, 32'h9ABCDEF0);
            s_rdata = pat;
            #3;
            check($sformatf("tbl%0d_gnt", i), 32'(gnt1), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_sreq", i), 32'(sreq1), 32'(tbl[i].sreq));
            @(posedge clk); #1;
            idle();
            #3;
            check($sformatf("tbl%0d_rvalid", i), 32'(rv1), 32'(tbl[i].rv));
            check($sformatf("tbl%0d_err", i), 32'(err1), 32'(tbl[i].err));
            check($sformatf("tbl%0d_rdata0", i), rd1[31:0], tbl[i].rd0);
            check($sformatf("tbl%0d_rdata1", i), rd1[63:32], tbl[i].rd1);
        end

        // ---------------- single read: bank offset ----------------
        do_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 14'h0804, 1'b0, 4'hF, 32'h0);
        s_rdata = pat;
        #3;
        check("single_addr_b1", 32'(saddr1[1*BAW +: BAW]), 32'h004);
        @(posedge clk); #1; idle(); #3;
        check("single_rdata", rd1[31:0], 32'hDEADBEEF);

        // ---------------- parallel write + read ----------------
        @(posedge clk); #1;
        drive(0, 1'b1, 14'h0000, 1'b1, 4'hF, 32'h12345678);
        drive(1, 1'b1, 14'h1804, 1'b0, 4'h0, 32'h0);
        #3;
        check("par_gnt", 32'(gnt1), 32'h3);
        check("par_b0_we_be", {27'h0, swe1[0], sbe1[3:0]}, {27'h0, 1'b1, 4'hF});
        check("par_b0_wdata", swd1[31:0], 32'h12345678);
        check("par_b3_addr_we", {20'h0, saddr1[3*BAW +: BAW], swe1[3]}, {20'h0, 11'h004, 1'b0});
        @(posedge clk); #1; idle(); #3;
        check("par_rvalid", 32'(rv1), 32'h3);
        check("par_rdata", {rd1[31:0]}, 32'h0);
        check("par_rdata1", rd1[63:32], 32'h33333333);

        // ---------------- contention held for 4 cycles ----------------
        do_reset();
        for (int c = 0; c < 5; c++) begin
            logic [1:0] eg;
            @(posedge clk); #1;
            if (c < 4) begin
                drive(0, 1'b1, 14'h1000, 1'b0, 4'hF, 32'h0);
                drive(1, 1'b1, 14'h1010, 1'b0, 4'hF, 32'h0);
            end else begin
                idle();
            end
            #3;
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            if (c < 4) begin
                check($sformatf("cont%0d_gnt", c), 32'(gnt1), 32'(eg));
                check($sformatf("cont%0d_addr", c), 32'(saddr1[2*BAW +: BAW]),
                      (c % 2 == 0) ? 32'h000 : 32'h010);
            end
            if (c > 0) begin
                check($sformatf("cont%0d_rvalid", c), 32'(rv1), (c % 2 == 1) ? 32'h1 : 32'h2);
            end
        end

        // ---------------- RD_LAT=2 back-to-back reads ----------------
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 3) drive(0, 1'b1, 14'(4 * c), 1'b0, 4'hF, 32'h0);
            else idle();
            s_rdata = '0;
            if (c >= 2 && c <= 4) s_rdata[31:0] = 32'h10000000 | 32'(4 * (c - 2));
            #3;
            check($sformatf("lat2_c%0d_rvalid", c), 32'(rv2[0]), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
            check($sformatf("lat2_c%0d_rdata", c), rd2[31:0],
                  (c >= 2 && c <= 4) ? (32'h10000000 | 32'(4 * (c - 2))) : 32'h0);
        end

        // ---------------- reset between grant and response ----------------
        do_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 14'h0800, 1'b0, 4'hF, 32'h0);
        #3;
        check("rst_pre_gnt", 32'(gnt1), 32'h1);
        @(posedge clk); #1;
        idle();
        #1 rst_n = 1'b0;
        #2;
        check("rst_during_rvalid", 32'(rv1), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 14'h0800, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 14'h0804, 1'b0, 4'hF, 32'h0);
        #3;
        check("rst_after_gnt", 32'(gnt1), 32'h1);
        check("rst_after_rvalid", {30'h0, rv2[0], rv1[0]}, 32'h0);
        @(posedge clk); #1; idle(); #3;
        check("rst_after_lat2_rvalid", 32'(rv2[0]), 32'h0);

        // ---------------- randomized run against model ----------------
        do_reset();
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        for (int c = 0; c < NCYC; c++) begin
            logic [AW-1:0] ma [NM];
            bit            mr [NM], mw [NM], moor [NM];
            int            mbk [NM];
            logic [3:0]    mbe [NM];
            logic [31:0]   mwd [NM];
            logic [1:0]    eg;
            logic [3:0]    esreq;
            logic [31:0]   ebank [NB], ewd [NB];
            int            nptr [NB];

            @(posedge clk); #1;
            for (int k = 0; k < NM; k++) begin
                mr[k]  = ($urandom_range(0, 9) < 7);
                ma[k]  = 14'($urandom_range(0, 8191));
                if ($urandom_range(0, 7) == 0) ma[k] = ma[k] + 14'h2000;
                mw[k]  = $urandom_range(0, 1) == 1;
                mbe[k] = 4'($urandom_range(0, 15));
                mwd[k] = $urandom;
                moor[k] = ma[k] >= 14'h2000;
                mbk[k]  = int'(ma[k] / 2048) % NB;
                drive(k, mr[k], ma[k], mw[k], mbe[k], mwd[k]);
            end
            s_rdata = {$urandom, $urandom, $urandom, $urandom};

            eg = '0; esreq = '0;
            for (int k = 0; k < NM; k++) if (mr[k] && moor[k]) eg[k] = 1'b1;
            for (int b = 0; b < NB; b++) begin
                int w;
                w = -1;
                ebank[b] = '0; ewd[b] = '0; nptr[b] = mptr[b];
                for (int i = 0; i < NM; i++) begin
                    int k;
                    k = (mptr[b] + i) % NM;
                    if (w < 0 && mr[k] && !moor[k] && mbk[k] == b) w = k;
                end
                if (w >= 0) begin
                    eg[w]    = 1'b1;
                    esreq[b] = 1'b1;
                    ebank[b] = {16'h0, 11'(ma[w] % 2048), mw[w], mbe[w]};
                    ewd[b]   = mwd[w];
                    nptr[b]  = (w + 1) % NM;
                end
            end
            #3;
            check("rnd_gnt", 32'(gnt1), 32'(eg));
            check("rnd_sreq", 32'(sreq1), 32'(esreq));
            for (int b = 0; b < NB; b++) begin
                check($sformatf("rnd_bank%0d_ctl", b),
                      {16'h0, saddr1[b*BAW +: BAW], swe1[b], sbe1[b*4 +: 4]}, ebank[b]);
                check($sformatf("rnd_bank%0d_wdata", b), swd1[b*32 +: 32], ewd[b]);
            end
            for (int k = 0; k < NM; k++) begin
                hv[c][k] = eg[k]; hb[c][k] = mbk[k]; he[c][k] = moor[k]; hw[c][k] = mw[k];
            end
            for (int lat = 1; lat <= 2; lat++) begin
                for (int k = 0; k < NM; k++) begin
                    bit          ev, ee;
                    logic [31:0] ed;
                    ev = 1'b0; ee = 1'b0; ed = '0;
                    if (c >= lat && hv[c-lat][k]) begin
                        ev = 1'b1;
                        ee = he[c-lat][k];
                        if (!he[c-lat][k] && !hw[c-lat][k]) ed = s_rdata[hb[c-lat][k]*32 +: 32];
                    end
                    check($sformatf("rnd_lat%0d_m%0d_rsp", lat, k),
                          (lat == 1) ? {30'h0, rv1[k], err1[k]} : {30'h0, rv2[k], err2[k]},
                          {30'h0, ev, ee});
                    check($sformatf("rnd_lat%0d_m%0d_rdata", lat, k),
                          (lat == 1) ? rd1[k*32 +: 32] : rd2[k*32 +: 32], ed);
                end
            end
            for (int b = 0; b < NB; b++) mptr[b] = nptr[b];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soric_bank_xbar.md
# soric_bank_xbar

Parametrised N-master x M-bank crossbar between the RISC-V core data/instruction ports and the dual-port SRAM macro banks in `soric_core`. It replaces the fixed 2-core/4-bank interconnect. It adds:
- per-bank round-robin arbitration;
- a configurable SRAM read latency;
- an error response for addresses outside the populated banks.

Master side is the ibex/flexbex req/gnt/rvalid protocol. Bank side drives one SRAM port (RW or R) per bank.

## Interface
Parameters:
- `NMASTER`, 2, number of requesting core ports (≥1).
- `NBANK`, 4, number of SRAM banks (power of two, ≥2); `BIDX_W = $clog2(NBANK)`.
- `ADDR_W`, 14, master byte-address width (≥ `BANK_ADDR_W + BIDX_W`).
- `BANK_ADDR_W`, 11, byte-address width inside one bank (2 kB = 11).
- `RD_LAT`, 1, cycles from bank request to valid `s_rdata_i` (≥1).

Ports:
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `m_req_i` in NMASTER: request per master.
- `m_addr_i` in NMASTER*ADDR_W: byte address, master k at [k*ADDR_W +: ADDR_W].
- `m_we_i` in NMASTER: write enable.
- `m_be_i` in NMASTER*4: byte enables.
- `m_wdata_i` in NMASTER*32: write data.
- `m_gnt_o` out NMASTER: grant, combinational, same cycle as the accepted request.
- `m_rvalid_o` out NMASTER: response valid.
- `m_rdata_o` out NMASTER*32: response data.
- `m_err_o` out NMASTER: error flag, qualified by `m_rvalid_o`.
- `s_req_o` out NBANK: bank chip-select (active-high; the wrapper inverts to csb).
- `s_addr_o` out NBANK*BANK_ADDR_W: byte address within bank.
- `s_we_o` out NBANK: bank write enable.
- `s_be_o` out NBANK*4: bank write mask.
- `s_wdata_o` out NBANK*32: bank write data.
- `s_rdata_i` in NBANK*32: bank read data, valid RD_LAT cycles after `s_req_o`.

## Operation
**Address decode** (per master)
- Bank index = `m_addr_i[BANK_ADDR_W +: BIDX_W]`.
- Offset = `m_addr_i[BANK_ADDR_W-1:0]`.
- Out-of-range = any bit of `m_addr_i[ADDR_W-1 : BANK_ADDR_W+BIDX_W]` set; false when that field is empty.

**Out-of-range requests**
- Granted immediately, without arbitration and without any bank access.
- Respond RD_LAT cycles later with `m_err_o=1` and `m_rdata_o=0`.

**Arbitration** (per bank, round-robin)
- Each bank has a priority pointer `ptr` of width `$clog2(NMASTER)`, reset to 0.
- Among in-range masters requesting that bank, the winner is the first index found scanning ptr, ptr+1, … mod NMASTER.
- On a grant to master k, `ptr` ← (k+1) mod NMASTER. With no grant, `ptr` holds.
- A master loses at most NMASTER-1 consecutive cycles while holding `m_req_i`.

**Bank drive**
- The winner's offset, we, be and wdata drive the bank and `s_req_o=1`.
- An idle bank drives `s_req_o=0` and all other bank outputs 0.

**Response pipeline** (per master)
- RD_LAT-deep shift register of {valid, bank index, err, we}, loaded on `m_gnt_o`.
- At the tap: `m_rvalid_o=valid`.
  - Reads: `m_rdata_o = s_rdata_i` of the recorded bank.
  - Writes and errors: `m_rdata_o = 0`.
  - `m_err_o = err`.
- Responses return strictly in grant order. One grant per master per cycle, so back-to-back requests are fully pipelined and never collide.
- Writes receive an rvalid as well, as the core protocol requires.

**Simultaneous events**
- Different masters to different banks: all granted the same cycle.
- A master never receives more than one grant per cycle.

**Reset**
- `rst_ni` low clears all pointers and pipeline valids immediately.
- In-flight responses are discarded and never delivered after reset release.

## Timing
- Reset values: `m_rvalid_o`, `m_err_o` = 0; `m_rdata_o` = 0; `m_gnt_o` and `s_*` follow the combinational path, and are 0 when no request is present.
- Latency:
  - `m_gnt_o` in the request cycle (cycle 0).
  - `s_req_o` in cycle 0.
  - `m_rvalid_o` in cycle RD_LAT.
- Throughput: one access per bank per cycle; one response per master per cycle.
- The only paths from `m_*` to `s_*` are decode + arbiter mux; there are no registers on the request path.

## Test plan
- **Single read:** RD_LAT=1; m0 reads 0x0804 with bank1 `s_rdata_i`=0xDEADBEEF.
  - Cycle 0: gnt0=1, `s_req_o`=4'b0010, `s_addr_o[bank1]`=0x004.
  - Cycle 1: rvalid0=1, rdata0=0xDEADBEEF, err0=0.
- **Contention:** m0 requests 0x1000 and m1 requests 0x1010 (both bank 2), both held for 4 cycles.
  - Grants alternate m0, m1, m0, m1.
  - Bank2 addresses alternate 0x000, 0x010.
  - Each rvalid follows its grant by 1 cycle.
- **Parallel:** m0 writes 0x0000 with be=4'hF, wdata=0x12345678; m1 reads 0x1804 in the same cycle.
  - Both granted.
  - Bank0: we=1, wdata=0x12345678.
  - Bank3: addr 0x004.
  - Next cycle: rvalid0=1 with rdata0=0, and rvalid1=1.
- **Out-of-range:** m1 reads 0x2000.
  - gnt1=1 and `s_req_o`=0.
  - RD_LAT cycles later: rvalid1=1, err1=1, rdata1=0.
- **Latency:** RD_LAT=2; m0 issues 3 back-to-back reads to bank0.
  - rvalid0 is high in cycles 2, 3, 4, with data in issue order.
- **Reset mid-operation:** rst_ni pulsed low in cycle 1, between grant and response.
  - rvalid0 stays 0 throughout.
  - After release, `ptr` = 0: the first contention goes to m0.
